// File: rtl/warp_registers.sv
// -----------------------------------------------------------------------------
// warp_registers
//
// Per-warp register file for a small SIMT core. Every thread of the warp owns
// one bank of NUM_REGISTERS registers. The low G = NUM_REGISTERS-3 registers
// are general purpose. The top three are read-only specials:
//   G   : block_id
//   G+1 : block_dim
//   G+2 : thread index t (zero-extended)
// A per-register scoreboard (busy) tracks registers with an outstanding
// producer. A read request is stalled while one of its sources is pending,
// unless the write-back that clears it lands in the same cycle. In that case
// the write data is forwarded into the read result.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   block_id, block_dim        values of the special registers G and G+1
//   thread_mask                per-thread write enable
//   rd_req_valid/rd_req_ready  read request handshake (ready is combinational)
//   rs_addr, rt_addr           read addresses
//   rs_data, rt_data           registered read data, thread t in slice t
//   rd_data_valid              one-cycle strobe for rs_data/rt_data
//   wr_en, wr_addr, reg_src    write-back strobe, destination and source select
//                              (00 ALU, 01 LSU, 10 IMM, 11 reserved)
//   immediate                  IMM value, broadcast to every thread
//   alu_result, lsu_result     per-thread write-back sources
//   reserve_en, reserve_addr   mark a general register pending
//   busy                       scoreboard; the special-register bits read as 0
// -----------------------------------------------------------------------------
module warp_registers #(
   parameter int DATA_WIDTH    = 8,
   parameter int NUM_THREADS   = 4,
   parameter int NUM_REGISTERS = 16,
   parameter int AW            = $clog2(NUM_REGISTERS)
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [DATA_WIDTH-1:0]             block_id,
   input  logic [DATA_WIDTH-1:0]             block_dim,
   input  logic [NUM_THREADS-1:0]            thread_mask,
   input  logic                              rd_req_valid,
   output logic                              rd_req_ready,
   input  logic [AW-1:0]                     rs_addr,
   input  logic [AW-1:0]                     rt_addr,
   output logic [NUM_THREADS*DATA_WIDTH-1:0] rs_data,
   output logic [NUM_THREADS*DATA_WIDTH-1:0] rt_data,
   output logic                              rd_data_valid,
   input  logic                              wr_en,
   input  logic [AW-1:0]                     wr_addr,
   input  logic [1:0]                        reg_src,
   input  logic [DATA_WIDTH-1:0]             immediate,
   input  logic [NUM_THREADS*DATA_WIDTH-1:0] alu_result,
   input  logic [NUM_THREADS*DATA_WIDTH-1:0] lsu_result,
   input  logic                              reserve_en,
   input  logic [AW-1:0]                     reserve_addr,
   output logic [NUM_REGISTERS-1:0]          busy
);

   localparam int            G      = NUM_REGISTERS - 3;
   localparam int            TW     = NUM_THREADS * DATA_WIDTH;
   localparam logic [AW-1:0] G_ADDR = AW'(G);
   localparam logic [AW-1:0] D_ADDR = AW'(G + 1);
   localparam logic [AW-1:0] T_ADDR = AW'(G + 2);

   localparam logic [1:0] SRC_ALU = 2'b00;
   localparam logic [1:0] SRC_LSU = 2'b01;
   localparam logic [1:0] SRC_IMM = 2'b10;

   // Register storage: only entries 0..G-1 exist as state.
   logic [DATA_WIDTH-1:0] r_regs [NUM_THREADS][G];
   logic [G-1:0]          r_busy;
   logic [TW-1:0]         r_rs_data;
   logic [TW-1:0]         r_rt_data;
   logic                  r_rd_data_valid;

   logic [DATA_WIDTH-1:0]    w_wr_val [NUM_THREADS];
   logic                     w_wr_data_en;
   logic [NUM_REGISTERS-1:0] w_busy_full;
   logic                     w_rs_blocked;
   logic                     w_rt_blocked;
   logic                     w_rd_ready;
   logic                     w_rd_accept;
   logic [TW-1:0]            w_rs_next;
   logic [TW-1:0]            w_rt_next;

   // ---------------------------------------------------------------------------
   // Write-back source selection
   // ---------------------------------------------------------------------------
   always_comb begin
      for (int t = 0; t < NUM_THREADS; t++) begin
         w_wr_val[t] = '0;
         unique case (reg_src)
            SRC_ALU: w_wr_val[t] = alu_result[t*DATA_WIDTH +: DATA_WIDTH];
            SRC_LSU: w_wr_val[t] = lsu_result[t*DATA_WIDTH +: DATA_WIDTH];
            SRC_IMM: w_wr_val[t] = immediate;
            default: w_wr_val[t] = '0;
         endcase
      end
   end

   // Data is written only for general destinations and a defined source.
   // The busy clear below uses wr_en alone, so a dropped write still
   // releases its scoreboard entry.
   assign w_wr_data_en = wr_en && (wr_addr < G_ADDR) && (reg_src != 2'b11);

   // ---------------------------------------------------------------------------
   // Scoreboard and read handshake
   // ---------------------------------------------------------------------------
   assign w_busy_full = {3'b000, r_busy};
   assign busy        = w_busy_full;

   // A pending source does not stall the read if this cycle's write-back
   // clears it. The forwarding path below then supplies the new value.
   assign w_rs_blocked = w_busy_full[rs_addr] && !(wr_en && (wr_addr == rs_addr));
   assign w_rt_blocked = w_busy_full[rt_addr] && !(wr_en && (wr_addr == rt_addr));
   assign w_rd_ready   = !(w_rs_blocked || w_rt_blocked);
   assign rd_req_ready = w_rd_ready;
   assign w_rd_accept  = rd_req_valid && w_rd_ready;

   // ---------------------------------------------------------------------------
   // Read word for one thread, with same-cycle write forwarding
   // ---------------------------------------------------------------------------
   function automatic logic [DATA_WIDTH-1:0] f_read_word(
      input int            t,
      input logic [AW-1:0] addr
   );
      logic [DATA_WIDTH-1:0] v;
      v = '0;
      if (addr < G_ADDR) begin
         for (int r = 0; r < G; r++) begin
            if (addr == AW'(r)) v = r_regs[t][r];
         end
         // Masked threads see the value being written this cycle.
         // Unmasked threads keep the stored value.
         if (w_wr_data_en && (wr_addr == addr) && thread_mask[t]) v = w_wr_val[t];
      end else if (addr == G_ADDR) begin
         v = block_id;
      end else if (addr == D_ADDR) begin
         v = block_dim;
      end else if (addr == T_ADDR) begin
         v = DATA_WIDTH'(t);
      end
      return v;
   endfunction

   always_comb begin
      w_rs_next = '0;
      w_rt_next = '0;
      for (int t = 0; t < NUM_THREADS; t++) begin
         w_rs_next[t*DATA_WIDTH +: DATA_WIDTH] = f_read_word(t, rs_addr);
         w_rt_next[t*DATA_WIDTH +: DATA_WIDTH] = f_read_word(t, rt_addr);
      end
   end

   // ---------------------------------------------------------------------------
   // Register file write
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int t = 0; t < NUM_THREADS; t++) begin
            for (int r = 0; r < G; r++) begin
               r_regs[t][r] <= '0;
            end
         end
      end else if (w_wr_data_en) begin
         for (int t = 0; t < NUM_THREADS; t++) begin
            for (int r = 0; r < G; r++) begin
               if (thread_mask[t] && (wr_addr == AW'(r))) r_regs[t][r] <= w_wr_val[t];
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Scoreboard update: a reserve beats a clear on the same register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy <= '0;
      end else begin
         for (int r = 0; r < G; r++) begin
            if (reserve_en && (reserve_addr == AW'(r))) begin
               r_busy[r] <= 1'b1;
            end else if (wr_en && (wr_addr == AW'(r))) begin
               r_busy[r] <= 1'b0;
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Read data register: loads only on an accepted read, otherwise holds
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rs_data       <= '0;
         r_rt_data       <= '0;
         r_rd_data_valid <= 1'b0;
      end else begin
         r_rd_data_valid <= w_rd_accept;
         if (w_rd_accept) begin
            r_rs_data <= w_rs_next;
            r_rt_data <= w_rt_next;
         end
      end
   end

   assign rs_data       = r_rs_data;
   assign rt_data       = r_rt_data;
   assign rd_data_valid = r_rd_data_valid;

endmodule

// File: tb/tb_warp_registers.sv
// -----------------------------------------------------------------------------
// tb_warp_registers
//
// Directed bench for warp_registers. It uses the default parameters:
// 8-bit data, 4 threads and 16 registers, so G = 13.
// -----------------------------------------------------------------------------
module tb_warp_registers;

   localparam int DW = 8;
   localparam int NT = 4;
   localparam int NR = 16;
   localparam int AW = 4;

   logic             clk;
   logic             rst_n;
   logic [DW-1:0]    block_id;
   logic [DW-1:0]    block_dim;
   logic [NT-1:0]    thread_mask;
   logic             rd_req_valid;
   logic             rd_req_ready;
   logic [AW-1:0]    rs_addr;
   logic [AW-1:0]    rt_addr;
   logic [NT*DW-1:0] rs_data;
   logic [NT*DW-1:0] rt_data;
   logic             rd_data_valid;
   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [1:0]       reg_src;
   logic [DW-1:0]    immediate;
   logic [NT*DW-1:0] alu_result;
   logic [NT*DW-1:0] lsu_result;
   logic             reserve_en;
   logic [AW-1:0]    reserve_addr;
   logic [NR-1:0]    busy;

   int n_checks;
   int n_errors;

   warp_registers #(
      .DATA_WIDTH   (DW),
      .NUM_THREADS  (NT),
      .NUM_REGISTERS(NR),
      .AW           (AW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .block_id     (block_id),
      .block_dim    (block_dim),
      .thread_mask  (thread_mask),
      .rd_req_valid (rd_req_valid),
      .rd_req_ready (rd_req_ready),
      .rs_addr      (rs_addr),
      .rt_addr      (rt_addr),
      .rs_data      (rs_data),
      .rt_data      (rt_data),
      .rd_data_valid(rd_data_valid),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .reg_src      (reg_src),
      .immediate    (immediate),
      .alu_result   (alu_result),
      .lsu_result   (lsu_result),
      .reserve_en   (reserve_en),
      .reserve_addr (reserve_addr),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and land 1 ns after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      rd_req_valid = 1'b0;
      wr_en        = 1'b0;
      reserve_en   = 1'b0;
      thread_mask  = 4'b0000;
      reg_src      = 2'b00;
   endtask

   initial begin
      n_checks     = 0;
      n_errors     = 0;
      rst_n        = 1'b0;
      block_id     = 8'd5;
      block_dim    = 8'd4;
      thread_mask  = '0;
      rd_req_valid = 1'b0;
      rs_addr      = '0;
      rt_addr      = '0;
      wr_en        = 1'b0;
      wr_addr      = '0;
      reg_src      = 2'b00;
      immediate    = '0;
      alu_result   = '0;
      lsu_result   = '0;
      reserve_en   = 1'b0;
      reserve_addr = '0;

      // Reset state
      #22;
      check("reset_busy",  64'(busy), 64'h0);
      check("reset_valid", 64'(rd_data_valid), 64'h0);
      check("reset_rs",    64'(rs_data), 64'h0);
      check("reset_rt",    64'(rt_data), 64'h0);
      rst_n = 1'b1;
      step();

      // Specials: rs=13 (block_id), rt=15 (thread index)
      rd_req_valid = 1'b1; rs_addr = 4'd13; rt_addr = 4'd15;
      #1;
      check("spec_ready", 64'(rd_req_ready), 64'h1);
      step();
      rd_req_valid = 1'b0;
      check("spec_valid", 64'(rd_data_valid), 64'h1);
      check("spec_rs",    64'(rs_data), 64'h05050505);
      check("spec_rt",    64'(rt_data), 64'h03020100);
      step();
      check("spec_valid_drop", 64'(rd_data_valid), 64'h0);
      check("spec_rs_hold",    64'(rs_data), 64'h05050505);

      // Masked ALU write to R2, then read it
      wr_en = 1'b1; wr_addr = 4'd2; reg_src = 2'b00; thread_mask = 4'b0101;
      alu_result = 32'h281E140A;
      step();
      idle_inputs();
      rd_req_valid = 1'b1; rs_addr = 4'd2; rt_addr = 4'd0;
      step();
      rd_req_valid = 1'b0;
      check("mask_rs", 64'(rs_data), 64'h001E000A);
      check("mask_rt", 64'(rt_data), 64'h00000000);

      // Same-cycle IMM write to R2 (threads 1,3) bypassed into a read
      wr_en = 1'b1; wr_addr = 4'd2; reg_src = 2'b10; immediate = 8'h55; thread_mask = 4'b1010;
      rd_req_valid = 1'b1; rs_addr = 4'd2; rt_addr = 4'd2;
      step();
      idle_inputs();
      check("bypass_rs", 64'(rs_data), 64'h551E550A);

      // Scoreboard: reserve R4, then a read is held off until the LSU write
      reserve_en = 1'b1; reserve_addr = 4'd4;
      step();
      reserve_en = 1'b0;
      check("sb_busy_set", 64'(busy), 64'h0010);
      rd_req_valid = 1'b1; rs_addr = 4'd4; rt_addr = 4'd0;
      #1;
      check("sb_ready_low", 64'(rd_req_ready), 64'h0);
      wr_en = 1'b1; wr_addr = 4'd4; reg_src = 2'b01; thread_mask = 4'b1111;
      lsu_result = 32'h77777777;
      #1;
      check("sb_ready_high", 64'(rd_req_ready), 64'h1);
      step();
      idle_inputs();
      check("sb_valid", 64'(rd_data_valid), 64'h1);
      check("sb_rs",    64'(rs_data), 64'h77777777);
      check("sb_busy_clr", 64'(busy), 64'h0000);

      // Collision: reserve and IMM-write R6 on one edge; the reserve wins
      reserve_en = 1'b1; reserve_addr = 4'd6;
      wr_en = 1'b1; wr_addr = 4'd6; reg_src = 2'b10; immediate = 8'h09; thread_mask = 4'b1111;
      step();
      idle_inputs();
      check("col_busy", 64'(busy), 64'h0040);
      rd_req_valid = 1'b1; rs_addr = 4'd6; rt_addr = 4'd6;
      #1;
      check("col_ready_low", 64'(rd_req_ready), 64'h0);
      step();
      check("col_blocked", 64'(rd_data_valid), 64'h0);
      // The reserved source drops its data but still releases R6, and the
      // read returns the value 9 stored by the collision edge.
      wr_en = 1'b1; wr_addr = 4'd6; reg_src = 2'b11; thread_mask = 4'b1111;
      #1;
      check("col_ready_high", 64'(rd_req_ready), 64'h1);
      step();
      idle_inputs();
      check("col_rs",   64'(rs_data), 64'h09090909);
      check("col_busy_clr", 64'(busy), 64'h0000);

      // Special-address write and reserve are both ignored
      wr_en = 1'b1; wr_addr = 4'd13; reg_src = 2'b10; immediate = 8'hFF; thread_mask = 4'b1111;
      reserve_en = 1'b1; reserve_addr = 4'd13;
      step();
      idle_inputs();
      check("spw_busy", 64'(busy), 64'h0000);
      rd_req_valid = 1'b1; rs_addr = 4'd13; rt_addr = 4'd14;
      step();
      rd_req_valid = 1'b0;
      check("spw_rs", 64'(rs_data), 64'h05050505);
      check("spw_rt", 64'(rt_data), 64'h04040404);

      // Back-to-back reads, one per cycle; reserve R3 along the way
      rd_req_valid = 1'b1; rs_addr = 4'd2; rt_addr = 4'd6;
      reserve_en = 1'b1; reserve_addr = 4'd3;
      step();
      reserve_en = 1'b0;
      check("b2b1_valid", 64'(rd_data_valid), 64'h1);
      check("b2b1_rs", 64'(rs_data), 64'h551E550A);
      check("b2b1_rt", 64'(rt_data), 64'h09090909);
      rs_addr = 4'd4; rt_addr = 4'd2;
      step();
      check("b2b2_valid", 64'(rd_data_valid), 64'h1);
      check("b2b2_rs", 64'(rs_data), 64'h77777777);
      check("b2b2_rt", 64'(rt_data), 64'h551E550A);
      check("b2b2_busy", 64'(busy), 64'h0008);

      // Asynchronous reset in the middle of a read, between clock edges
      #1;
      rst_n = 1'b0;
      #1;
      check("arst_valid", 64'(rd_data_valid), 64'h0);
      check("arst_busy",  64'(busy), 64'h0);
      check("arst_rs",    64'(rs_data), 64'h0);
      check("arst_rt",    64'(rt_data), 64'h0);
      #1;
      rst_n = 1'b1;
      rs_addr = 4'd2; rt_addr = 4'd4;
      step();
      rd_req_valid = 1'b0;
      check("post_rst_valid", 64'(rd_data_valid), 64'h1);
      check("post_rst_rs", 64'(rs_data), 64'h0);
      check("post_rst_rt", 64'(rt_data), 64'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
